// File: rtl/router_fsm_np.sv
// rtl/router_fsm_np.sv - N-port router controller FSM; optional wait-state timeout under WAIT_TIMEOUT_EN
module router_fsm_np #(
    parameter int NUM_PORTS      = 3,
    parameter int ADDR_W         = 2,
    parameter int TIMEOUT_CYCLES = 30
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 full_state,
    output logic                 laf_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] dest_sel,
    output logic                 drop_state,
    output logic                 timeout_err
);

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        WAIT_TILL_EMPTY    = 4'd2,
        LOAD_DATA          = 4'd3,
        LOAD_PARITY        = 4'd4,
        CHECK_PARITY_ERROR = 4'd5,
        FIFO_FULL_STATE    = 4'd6,
        LOAD_AFTER_FULL    = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [NUM_PORTS-1:0] dest_nxt;
    logic [NUM_PORTS-1:0] addr_onehot;
    logic                 addr_valid;
    logic                 sel_empty;
    logic                 sel_rst;
    logic                 tout_hit;

    assign addr_valid  = (32'(data_in) < NUM_PORTS);
    assign addr_onehot = NUM_PORTS'(1) << data_in;
    // Wait and soft-reset decisions use the latched destination, never live data_in.
    assign sel_empty   = |(fifo_empty & dest_sel);
    assign sel_rst     = |(soft_reset & dest_sel);

`ifdef WAIT_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt;

    assign tout_hit = (state == WAIT_TILL_EMPTY) && !sel_empty &&
                      (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tout_hit && !sel_rst;
            if (state != WAIT_TILL_EMPTY)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign tout_hit    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= DECODE_ADDRESS;
            dest_sel <= '0;
        end else begin
            state    <= state_nxt;
            dest_sel <= dest_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dest_nxt  = dest_sel;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (!addr_valid) begin
                        state_nxt = DROP_PACKET;
                    end else begin
                        dest_nxt  = addr_onehot;
                        state_nxt = (|(fifo_empty & addr_onehot)) ? LOAD_FIRST_DATA
                                                                  : WAIT_TILL_EMPTY;
                    end
                end
            end
            WAIT_TILL_EMPTY: begin
                if (sel_empty)
                    state_nxt = LOAD_FIRST_DATA;
                else if (tout_hit)
                    state_nxt = DROP_PACKET;
            end
            LOAD_FIRST_DATA:    state_nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    state_nxt = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    state_nxt = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    state_nxt = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    state_nxt = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    state_nxt = LOAD_PARITY;
                else
                    state_nxt = LOAD_DATA;
            end
            LOAD_PARITY:        state_nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            DROP_PACKET: begin
                if (!pkt_valid)
                    state_nxt = DECODE_ADDRESS;
            end
            default:            state_nxt = DECODE_ADDRESS;
        endcase
        if ((state != DECODE_ADDRESS) && sel_rst)
            state_nxt = DECODE_ADDRESS;
    end

    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign drop_state    = (state == DROP_PACKET);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                           (state == LOAD_AFTER_FULL);
    // Dropping keeps busy low so the source can drain the unwanted packet.
    assign busy          = (state == LOAD_FIRST_DATA) || (state == LOAD_PARITY) ||
                           (state == FIFO_FULL_STATE) || (state == LOAD_AFTER_FULL) ||
                           (state == WAIT_TILL_EMPTY) || (state == CHECK_PARITY_ERROR);

endmodule

// File: tb/tb_router_fsm_np.sv
// tb/tb_router_fsm_np.sv - directed and randomized checks of router_fsm_np against a behavioural model
module tb_router_fsm_np;

    localparam int N  = 3;
    localparam int AW = 2;
    localparam int T  = 30;
`ifdef WAIT_TIMEOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif

    localparam int S_DA = 0, S_LFD = 1, S_WAIT = 2, S_LD = 3, S_LP = 4;
    localparam int S_CPE = 5, S_FULL = 6, S_LAF = 7, S_DROP = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          pkt_valid;
    logic [AW-1:0] data_in;
    logic          fifo_full;
    logic [N-1:0]  fifo_empty;
    logic [N-1:0]  soft_reset;
    logic          parity_done;
    logic          low_pkt_valid;
    logic          detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
    logic          write_enb_reg, busy, drop_state, timeout_err;
    logic [N-1:0]  dest_sel;

    int n_checks = 0;
    int n_fail   = 0;

    int m_state = S_DA;
    int m_port  = -1;
    int m_wait  = 0;
    bit m_tout  = 1'b0;

    router_fsm_np #(.NUM_PORTS(N), .ADDR_W(AW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .dest_sel(dest_sel),
        .drop_state(drop_state), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // {detect, lfd, ld, full, laf, cpe, drop, write_enb, busy, timeout_err}
    function automatic logic [9:0] dut_vec();
        return {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
                drop_state, write_enb_reg, busy, timeout_err};
    endfunction

    function automatic logic [9:0] exp_vec(int s, bit tout);
        logic [9:0] v;
        case (s)
            S_DA:    v = 10'b1000000000;
            S_LFD:   v = 10'b0100000010;
            S_WAIT:  v = 10'b0000000010;
            S_LD:    v = 10'b0010000100;
            S_LP:    v = 10'b0000000110;
            S_CPE:   v = 10'b0000010010;
            S_FULL:  v = 10'b0001000010;
            S_LAF:   v = 10'b0000100110;
            S_DROP:  v = 10'b0000001000;
            default: v = 10'bxxxxxxxxxx;
        endcase
        v[0] = tout;
        return v;
    endfunction

    function automatic logic [N-1:0] port_onehot(int p);
        logic [N-1:0] v = '0;
        if (p >= 0) v[p] = 1'b1;
        return v;
    endfunction

    // Advance one clock; the model applies the router rules to the inputs present now.
    task automatic cycle();
        int ns = m_state;
        int np = m_port;
        int nw = m_wait;
        bit nt = 1'b0;
        bit s_rst = (m_port >= 0) && soft_reset[m_port];
        bit s_emp = (m_port >= 0) && fifo_empty[m_port];
        if (!resetn) begin
            ns = S_DA; np = -1; nw = 0;
        end else begin
            case (m_state)
                S_DA: if (pkt_valid) begin
                    if (int'(data_in) >= N) ns = S_DROP;
                    else begin
                        np = int'(data_in);
                        ns = fifo_empty[data_in] ? S_LFD : S_WAIT;
                        nw = 0;
                    end
                end
                S_WAIT: begin
                    if (s_emp) ns = S_LFD;
                    else if (TOUT_EN && (m_wait + 1 >= T)) begin ns = S_DROP; nt = 1'b1; end
                    else nw = m_wait + 1;
                end
                S_LFD:  ns = S_LD;
                S_LD:   if (fifo_full) ns = S_FULL; else if (!pkt_valid) ns = S_LP;
                S_FULL: if (!fifo_full) ns = S_LAF;
                S_LAF:  ns = parity_done ? S_DA : (low_pkt_valid ? S_LP : S_LD);
                S_LP:   ns = S_CPE;
                S_CPE:  ns = fifo_full ? S_FULL : S_DA;
                S_DROP: if (!pkt_valid) ns = S_DA;
                default: ns = S_DA;
            endcase
            if ((m_state != S_DA) && s_rst) begin ns = S_DA; nt = 1'b0; end
        end
        @(posedge clk);
        #1;
        m_state = ns; m_port = np; m_wait = nw; m_tout = nt;
    endtask

    task automatic test_reset();
        resetn = 1'b0; pkt_valid = 1'b0; data_in = '0; fifo_full = 1'b0;
        fifo_empty = '1; soft_reset = '0; parity_done = 1'b0; low_pkt_valid = 1'b0;
        cycle(); cycle();
        n_checks++;
        if (dut_vec() !== exp_vec(S_DA, 0)) begin
            n_fail++; $display("FAIL reset_outputs got %b exp %b", dut_vec(), exp_vec(S_DA, 0));
        end
        n_checks++;
        if (dest_sel !== 3'b000) begin
            n_fail++; $display("FAIL reset_dest_sel got %b exp 000", dest_sel);
        end
        resetn = 1'b1;
    endtask

    task automatic test_basic_port2();
        int exp_s[8];
        int we_cnt = 0;
        exp_s = '{S_LFD, S_LD, S_LD, S_LD, S_LD, S_LP, S_CPE, S_DA};
        fifo_empty = '1; data_in = 2'd2; pkt_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) pkt_valid = 1'b0;
            cycle();
            if (write_enb_reg) we_cnt++;
            n_checks++;
            if (dut_vec() !== exp_vec(exp_s[i], 0)) begin
                n_fail++; $display("FAIL basic_seq[%0d] got %b exp %b", i, dut_vec(), exp_vec(exp_s[i], 0));
            end
        end
        n_checks++;
        if (dest_sel !== 3'b100) begin n_fail++; $display("FAIL basic_dest got %b exp 100", dest_sel); end
        n_checks++;
        if (we_cnt != 5) begin n_fail++; $display("FAIL basic_we_cycles got %0d exp 5", we_cnt); end
    endtask

    task automatic test_drop();
        int drops = 0;
        data_in = 2'd3; pkt_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) pkt_valid = 1'b0;
            cycle();
            if (drop_state) drops++;
            n_checks++;
            if (dut_vec() !== exp_vec((i < 6) ? S_DROP : S_DA, 0)) begin
                n_fail++; $display("FAIL drop_seq[%0d] got %b exp %b", i, dut_vec(),
                                   exp_vec((i < 6) ? S_DROP : S_DA, 0));
            end
        end
        n_checks++;
        if (drops != 6) begin n_fail++; $display("FAIL drop_cycles got %0d exp 6", drops); end
        n_checks++;
        if (dest_sel !== 3'b100) begin n_fail++; $display("FAIL drop_dest_hold got %b exp 100", dest_sel); end
    endtask

    task automatic test_wait_empty();
        int exp_s[10];
        exp_s = '{S_WAIT, S_WAIT, S_WAIT, S_WAIT, S_WAIT, S_LFD, S_LD, S_LP, S_CPE, S_DA};
        fifo_empty = 3'b110; data_in = 2'd0; pkt_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) data_in = 2'd1;
            if (i == 5) fifo_empty = 3'b111;
            if (i == 6) pkt_valid = 1'b0;
            cycle();
            n_checks++;
            if (dut_vec() !== exp_vec(exp_s[i], 0)) begin
                n_fail++; $display("FAIL wait_seq[%0d] got %b exp %b", i, dut_vec(), exp_vec(exp_s[i], 0));
            end
            if (i == 3) begin
                n_checks++;
                if (dest_sel !== 3'b001) begin n_fail++; $display("FAIL wait_dest got %b exp 001", dest_sel); end
            end
        end
    endtask

    task automatic test_full_stall();
        int exp_s[9];
        exp_s = '{S_LFD, S_LD, S_FULL, S_FULL, S_FULL, S_LAF, S_LP, S_CPE, S_DA};
        fifo_empty = '1; data_in = 2'd1; pkt_valid = 1'b1; parity_done = 1'b0; low_pkt_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 2) fifo_full = 1'b1;
            if (i == 5) fifo_full = 1'b0;
            if (i == 8) pkt_valid = 1'b0;
            cycle();
            n_checks++;
            if (dut_vec() !== exp_vec(exp_s[i], 0)) begin
                n_fail++; $display("FAIL full_seq[%0d] got %b exp %b", i, dut_vec(), exp_vec(exp_s[i], 0));
            end
        end
        low_pkt_valid = 1'b0;
    endtask

    task automatic test_soft_reset();
        int exp_s[5];
        exp_s = '{S_LFD, S_LD, S_LD, S_FULL, S_DA};
        fifo_empty = '1; data_in = 2'd1; pkt_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) soft_reset = 3'b100;
            if (i == 3) begin soft_reset = 3'b000; fifo_full = 1'b1; end
            if (i == 4) soft_reset = 3'b010;
            cycle();
            n_checks++;
            if (dut_vec() !== exp_vec(exp_s[i], 0)) begin
                n_fail++; $display("FAIL soft_seq[%0d] got %b exp %b", i, dut_vec(), exp_vec(exp_s[i], 0));
            end
        end
        soft_reset = '0; fifo_full = 1'b0; pkt_valid = 1'b0;
        cycle();
    endtask

    task automatic test_wait_timeout();
        int  waits = 0;
        int  touts = 0;
        bit  seen_drop = 1'b0;
        bit  tout_on_drop = 1'b0;
        fifo_empty = '0; data_in = 2'd0; pkt_valid = 1'b1;
        cycle();
        if (dut_vec() === exp_vec(S_WAIT, 0)) waits++;
        for (int i = 0; i < 60 && !seen_drop; i++) begin
            cycle();
            if (timeout_err) touts++;
            if (drop_state) begin seen_drop = 1'b1; tout_on_drop = timeout_err; end
            else if (dut_vec() === exp_vec(S_WAIT, 0)) waits++;
        end
        pkt_valid = 1'b0;
        if (!TOUT_EN) fifo_empty = '1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (timeout_err) touts++;
        end
        n_checks++;
        if (seen_drop !== TOUT_EN) begin n_fail++; $display("FAIL tout_drop got %0d exp %0d", seen_drop, TOUT_EN); end
        n_checks++;
        if (waits != (TOUT_EN ? T : 61)) begin
            n_fail++; $display("FAIL tout_wait_cycles got %0d exp %0d", waits, TOUT_EN ? T : 61);
        end
        n_checks++;
        if (touts != (TOUT_EN ? 1 : 0) || tout_on_drop !== TOUT_EN) begin
            n_fail++; $display("FAIL tout_pulse got %0d/%0d exp %0d", touts, tout_on_drop, TOUT_EN);
        end
        n_checks++;
        if (detect_add !== 1'b1) begin n_fail++; $display("FAIL tout_return got %b exp 1", detect_add); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            resetn        = ($urandom_range(0, 199) != 0);
            pkt_valid     = ($urandom_range(0, 9) < 8);
            data_in       = AW'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 3) == 0);
            fifo_empty    = N'($urandom);
            soft_reset    = ($urandom_range(0, 19) == 0) ? N'($urandom) : '0;
            parity_done   = ($urandom_range(0, 9) < 3);
            low_pkt_valid = ($urandom_range(0, 9) < 3);
            cycle();
            n_checks++;
            if (dut_vec() !== exp_vec(m_state, m_tout)) begin
                n_fail++; $display("FAIL rand_outputs[%0d] got %b exp %b", i, dut_vec(), exp_vec(m_state, m_tout));
            end
            n_checks++;
            if (dest_sel !== port_onehot(m_port)) begin
                n_fail++; $display("FAIL rand_dest[%0d] got %b exp %b", i, dest_sel, port_onehot(m_port));
            end
        end
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_port2();
        test_drop();
        test_wait_empty();
        test_full_stall();
        test_soft_reset();
        test_wait_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_fsm_np.md
Name: router_fsm_np

Overview:
- Parametrised controller FSM for an N-port packet router. It sits between the input register block and the N output FIFOs.
- Decodes the header address and latches a one-hot destination.
- Sequences first-data, payload, full-stall and parity loads.
- Drops packets with an out-of-range address.
- Aborts cleanly on a soft reset from the selected port only.

Parameters:
- NUM_PORTS, 3, number of output ports/FIFOs (2..8)
- ADDR_W, 2, header address width; must satisfy 2**ADDR_W >= NUM_PORTS
- TIMEOUT_CYCLES, 30, maximum WAIT_TILL_EMPTY dwell before the packet is dropped (used only with WAIT_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  synchronous, active-low reset
- pkt_valid  in  1  packet in progress from source
- data_in  in  ADDR_W  header address bits, sampled in DECODE_ADDRESS
- fifo_full  in  1  full flag of the currently selected FIFO
- fifo_empty  in  NUM_PORTS  per-port FIFO empty flags
- soft_reset  in  NUM_PORTS  per-port soft-reset pulses
- parity_done  in  1  parity byte already captured by register block
- low_pkt_valid  in  1  pkt_valid fell while stalled
- detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg  out  1 each  state decodes
- write_enb_reg  out  1  FIFO write enable
- busy  out  1  source must hold data
- dest_sel  out  NUM_PORTS  one-hot latched destination
- drop_state  out  1  packet being discarded
- timeout_err  out  1  one-cycle pulse on wait timeout

Behaviour:
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, WAIT_TILL_EMPTY, LOAD_DATA, LOAD_PARITY, CHECK_PARITY_ERROR, FIFO_FULL_STATE, LOAD_AFTER_FULL, DROP_PACKET.
- Reset: state=DECODE_ADDRESS, dest_sel=0, wait counter=0, timeout_err=0. Outputs follow the state decode, so detect_add=1 and all other outputs are 0.
- Address valid when data_in < NUM_PORTS; a = data_in.
- DECODE_ADDRESS:
  - pkt_valid and invalid address -> DROP_PACKET.
  - pkt_valid, valid address, fifo_empty[a] -> LOAD_FIRST_DATA.
  - pkt_valid, valid address, !fifo_empty[a] -> WAIT_TILL_EMPTY.
  - Otherwise stay.
  - dest_sel <= onehot(a) on the transition with a valid address. dest_sel holds at all other times, including DROP.
- WAIT_TILL_EMPTY: selected FIFO empty (fifo_empty & dest_sel nonzero) -> LOAD_FIRST_DATA, else stay. Uses the latched dest_sel, never data_in.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
- LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
- FIFO_FULL_STATE: stay while fifo_full, else -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
- DROP_PACKET: stay while pkt_valid, -> DECODE_ADDRESS when pkt_valid=0. No FIFO writes.
- Soft reset: if (soft_reset & dest_sel) is nonzero in any state except DECODE_ADDRESS, next state = DECODE_ADDRESS. This has priority over all other transitions. Soft resets on non-selected ports are ignored.
- Output decodes (Moore, from present state only):
  - detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; full_state=FIFO_FULL_STATE; laf_state=LOAD_AFTER_FULL; rst_int_reg=CHECK_PARITY_ERROR; drop_state=DROP_PACKET.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = LOAD_FIRST_DATA | LOAD_PARITY | FIFO_FULL_STATE | LOAD_AFTER_FULL | WAIT_TILL_EMPTY | CHECK_PARITY_ERROR.
  - busy=0 in DROP_PACKET so the source drains.
- Unreachable state encodings -> DECODE_ADDRESS next cycle.

Optional Feature:
- Macro: WAIT_TIMEOUT_EN.
- Defined:
  - Counter of width clog2(TIMEOUT_CYCLES) clears on entry to WAIT_TILL_EMPTY and increments each cycle in it.
  - If count == TIMEOUT_CYCLES-1 and the selected FIFO is still not empty, next state = DROP_PACKET and timeout_err=1 for that one cycle (registered).
  - Selected FIFO empty on the same cycle wins -> LOAD_FIRST_DATA.
  - Soft reset still has top priority.
- Undefined: no counter logic, timeout_err tied 0, WAIT_TILL_EMPTY waits indefinitely.

Test Plan:
- NUM_PORTS=3, all FIFOs empty, header data_in=2, 4 payload cycles then pkt_valid=0 -> dest_sel=3'b100; state sequence DECODE, LFD, LD x4, LP, CPE, DECODE; write_enb_reg high for 5 cycles.
- Header data_in=3 with NUM_PORTS=3, pkt_valid for 6 cycles -> DROP_PACKET for 6 cycles; write_enb_reg=0, busy=0, drop_state=1; returns to DECODE when pkt_valid falls.
- fifo_empty=3'b110, header data_in=0; data_in changes to 1 during wait; fifo_empty[0] rises after 5 cycles -> stays in WAIT 5 cycles, then LFD; dest_sel stays 3'b001.
- In LOAD_DATA, fifo_full=1 for 3 cycles then 0, with parity_done=0 and low_pkt_valid=1 -> FULL x3, LAF, LP, CPE.
- Destination port 1: soft_reset=3'b100 in LOAD_DATA -> no effect; soft_reset=3'b010 in FIFO_FULL_STATE -> DECODE next cycle.
- WAIT_TIMEOUT_EN, TIMEOUT_CYCLES=30, destination FIFO never empties -> DROP_PACKET after 30 WAIT cycles with a single-cycle timeout_err pulse.
